// File: rtl/pwm_multi_ch.sv
// pwm_multi_ch: multi-channel PWM generator. One shared period counter drives
// CHANNELS comparators; each channel has a double-buffered (shadow/active)
// duty value so updates only take effect at a period boundary.
// Build option: define PWM_CENTER_ALIGN_EN to add the ctr_mode input and
// up/down (center-aligned) counting; without it the counter is edge-aligned.
module pwm_multi_ch #(
   parameter int WIDTH    = 10,
   parameter int CHANNELS = 2
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      en,
   input  logic [CHANNELS*WIDTH-1:0] duty_in,
   input  logic                      upd_req,
`ifdef PWM_CENTER_ALIGN_EN
   input  logic                      ctr_mode,
`endif
   output logic                      upd_pend,
   output logic                      per_start,
   output logic [CHANNELS-1:0]       pwm_out
);

   localparam logic [WIDTH-1:0] MAX = {WIDTH{1'b1}};

   logic [WIDTH-1:0] cnt;
   logic [WIDTH-1:0] cnt_nxt;
   logic             boundary;
   logic [WIDTH-1:0] shadow  [CHANNELS];
   logic [WIDTH-1:0] active  [CHANNELS];
   logic [WIDTH-1:0] act_nxt [CHANNELS];

`ifdef PWM_CENTER_ALIGN_EN
   logic mode_act;
   logic down;

   // Next count and period boundary: edge mode wraps at MAX (boundary = TC),
   // center mode turns around at MAX and at 1 (boundary = valley, cnt==0).
   always_comb begin
      cnt_nxt  = cnt + 1'b1;
      boundary = en && (cnt == MAX);
      if (mode_act) begin
         boundary = en && (cnt == '0);
         if (down) begin
            cnt_nxt = cnt - 1'b1;
         end else if (cnt == MAX) begin
            cnt_nxt = MAX - 1'b1;
         end
      end
   end

   // Count direction and the mode in force; mode only changes at a boundary
   // or while stopped, so a period is never cut short.
   always_ff @(posedge clk) begin
      if (rst) begin
         mode_act <= 1'b0;
         down     <= 1'b0;
      end else if (!en) begin
         mode_act <= ctr_mode;
         down     <= 1'b0;
      end else begin
         if (boundary) begin
            mode_act <= ctr_mode;
         end
         if (mode_act) begin
            if (!down && (cnt == MAX)) begin
               down <= 1'b1;
            end else if (down && (cnt == WIDTH'(1))) begin
               down <= 1'b0;
            end
         end else begin
            down <= 1'b0;
         end
      end
   end
`else
   // Next count and period boundary: free-running wrap, boundary at TC.
   always_comb begin
      cnt_nxt  = cnt + 1'b1;
      boundary = en && (cnt == MAX);
   end
`endif

   // Active duty for the coming cycle: reload from shadow (or straight from
   // duty_in when a request lands on the same cycle) at a boundary or while
   // stopped; otherwise hold.
   always_comb begin
      for (int i = 0; i < CHANNELS; i++) begin
         act_nxt[i] = active[i];
         if (!en || boundary) begin
            act_nxt[i] = upd_req ? duty_in[i*WIDTH +: WIDTH] : shadow[i];
         end
      end
   end

   // Counter, shadow/active duty registers and the update-pending flag.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt      <= '0;
         upd_pend <= 1'b0;
         for (int i = 0; i < CHANNELS; i++) begin
            shadow[i] <= '0;
            active[i] <= '0;
         end
      end else begin
         cnt <= en ? cnt_nxt : '0;
         for (int i = 0; i < CHANNELS; i++) begin
            if (upd_req) begin
               shadow[i] <= duty_in[i*WIDTH +: WIDTH];
            end
            active[i] <= act_nxt[i];
         end
         if (!en || boundary) begin
            upd_pend <= 1'b0;
         end else if (upd_req) begin
            upd_pend <= 1'b1;
         end
      end
   end

   // Registered outputs. Comparing against act_nxt lets the valley cycle of a
   // center-aligned period already use the newly loaded duty; in edge mode
   // the boundary cycle has cnt==MAX, where the compare is false either way.
   always_ff @(posedge clk) begin
      if (rst) begin
         pwm_out   <= '0;
         per_start <= 1'b0;
      end else begin
         per_start <= en && (cnt == '0);
         for (int i = 0; i < CHANNELS; i++) begin
            pwm_out[i] <= en && (cnt < act_nxt[i]);
         end
      end
   end

endmodule

// File: tb/tb_pwm_multi_ch.sv
// tb_pwm_multi_ch: scoreboard bench for pwm_multi_ch (WIDTH=4, CHANNELS=2,
// edge-aligned build). The stimulus queues one expected waveform per period;
// the monitor pops one entry per per_start and compares 16 sampled cycles.
module tb_pwm_multi_ch;

   localparam int W  = 4;
   localparam int CH = 2;

   logic            clk = 1'b0;
   logic            rst;
   logic            en;
   logic            upd_req;
   logic [CH*W-1:0] duty_in;
   logic            upd_pend;
   logic            per_start;
   logic [CH-1:0]   pwm_out;

   int total  = 0;
   int bad    = 0;
   int edge_n = 0;
   bit mon_busy = 1'b0;

   typedef struct {
      string       name;
      int          hi0;
      int          hi1;
      logic [15:0] pend;
   } exp_t;

   exp_t exp_q[$];

   pwm_multi_ch #(.WIDTH(W), .CHANNELS(CH)) dut (
      .clk       (clk),
      .rst       (rst),
      .en        (en),
      .duty_in   (duty_in),
      .upd_req   (upd_req),
      .upd_pend  (upd_pend),
      .per_start (per_start),
      .pwm_out   (pwm_out)
   );

   always #5 clk = ~clk;

   always @(posedge clk) edge_n <= edge_n + 1;

   task automatic chk(input string nm, input logic [15:0] got, input logic [15:0] want);
      total++;
      if (got !== want) begin
         bad++;
         $display("FAIL %s: got=%h want=%h", nm, got, want);
      end
   endtask

   function automatic logic [15:0] ones(input int n);
      logic [31:0] t;
      t = (32'd1 << n) - 32'd1;
      return t[15:0];
   endfunction

   task automatic push(input string nm, input int h0, input int h1, input logic [15:0] pd);
      exp_t e;
      e.name = nm;
      e.hi0  = h0;
      e.hi1  = h1;
      e.pend = pd;
      exp_q.push_back(e);
   endtask

   // Returns 1 ns after the posedge numbered n (edges counted from 1).
   task automatic wait_edge(input int n);
      while (edge_n < n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic set_duty(input int c0, input int c1);
      logic [W-1:0] d0;
      logic [W-1:0] d1;
      d0 = W'(c0);
      d1 = W'(c1);
      duty_in = {d1, d0};
   endtask

   // Monitor: one full period per queued expectation, sampled on negedges.
   initial begin
      exp_t        e;
      logic [15:0] w0, w1, ps, pd;
      forever begin
         @(negedge clk);
         if (per_start && exp_q.size() > 0) begin
            mon_busy = 1'b1;
            e  = exp_q.pop_front();
            w0 = '0; w1 = '0; ps = '0; pd = '0;
            for (int k = 0; k < 16; k++) begin
               if (k > 0) @(negedge clk);
               w0[k] = pwm_out[0];
               w1[k] = pwm_out[1];
               ps[k] = per_start;
               pd[k] = upd_pend;
            end
            chk({e.name, "_ch0"},  w0, ones(e.hi0));
            chk({e.name, "_ch1"},  w1, ones(e.hi1));
            chk({e.name, "_pst"},  ps, 16'h0001);
            chk({e.name, "_pend"}, pd, e.pend);
            mon_busy = 1'b0;
         end
      end
   end

   // Stimulus: edge numbers below are posedges; output of edge 4+k has cnt=k mod 16.
   initial begin
      rst = 1'b1; en = 1'b0; upd_req = 1'b0; duty_in = '0;
      wait_edge(2);
      chk("rst_pwm",  {14'b0, pwm_out}, 16'd0);
      chk("rst_pst",  {15'b0, per_start}, 16'd0);
      chk("rst_pend", {15'b0, upd_pend}, 16'd0);
      rst = 1'b0; upd_req = 1'b1; set_duty(5, 0);
      wait_edge(3);
      upd_req = 1'b0; en = 1'b1;
      push("A_first",   5,  0, 16'h0000);
      push("B_midupd",  5,  0, 16'h7F80);
      push("C_twoupd", 12,  3, 16'h7FFC);
      push("D_tcupd",   9,  7, 16'h0000);
      push("E_bypass",  2, 14, 16'h7FF0);
      push("F_extreme",15,  0, 16'h0000);
      // period B: update at cnt=7
      wait_edge(26); upd_req = 1'b1; set_duty(12, 3);
      wait_edge(27); upd_req = 1'b0;
      // period C: two updates, the later one wins
      wait_edge(37); upd_req = 1'b1; set_duty(3, 3);
      wait_edge(38); upd_req = 1'b0;
      wait_edge(45); upd_req = 1'b1; set_duty(9, 7);
      wait_edge(46); upd_req = 1'b0;
      // period D: update exactly at cnt=15 (bypass)
      wait_edge(66); upd_req = 1'b1; set_duty(2, 14);
      wait_edge(67); upd_req = 1'b0;
      // period E: load boundary duties
      wait_edge(71); upd_req = 1'b1; set_duty(15, 0);
      wait_edge(72); upd_req = 1'b0;
      // period G: reset at cnt=3
      wait_edge(102); rst = 1'b1;
      wait_edge(103); rst = 1'b0;
      chk("mid_rst_pwm",  {14'b0, pwm_out}, 16'd0);
      chk("mid_rst_pst",  {15'b0, per_start}, 16'd0);
      chk("mid_rst_pend", {15'b0, upd_pend}, 16'd0);
      push("H_after_rst", 0, 0, 16'h0000);
      wait_edge(125);
      chk("sb_drain", 16'(exp_q.size()), 16'd0);
      chk("mon_idle", {15'b0, mon_busy}, 16'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #5000;
      $display("FAIL watchdog: got=timeout want=finish");
      $fatal(1, "watchdog expired");
   end

endmodule
